sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised successor to the dual-clock sample FIFO. It buffers ADC/DSP sample words between the acquisition chain and the readout path. It supports two modes:
- Streaming: true FIFO with simultaneous read and write.
- Block: fill-to-full, then drain-to-empty, used per VNA sweep point.
It adds occupancy count, almost-full/almost-empty thresholds, registered read data with a valid strobe, and sticky error flags.

Parameters:
addr_width, 12, log2 of storage depth; depth = 2^addr_width, all entries usable
data_width, 24, sample word width
af_thresh, (1<<addr_width)-4, almost_full asserted when count >= af_thresh
ae_thresh, 4, almost_empty asserted when count <= ae_thresh

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
block_mode  in  1  requested mode: 0 streaming, 1 block; latched only while empty
write_en  in  1  write request
din  in  data_width  write data
read_en  in  1  read request
clear_err  in  1  clears sticky error flags
dout  out  data_width  registered read data
dout_valid  out  1  one-cycle strobe: dout carries newly read word
full  out  1  count == depth
empty  out  1  count == 0
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh
data_count  out  addr_width+1  occupancy, 0..depth
direction  out  1  block mode: 0 fill, 1 drain; always 0 in streaming
overflow_err  out  1  sticky: rejected write
underflow_err  out  1  sticky: rejected read

Behaviour:
- Reset (async assert, sync-to-clk release):
  - wptr = rptr = 0, data_count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - dout = 0, dout_valid = 0, direction = 0, both errors = 0, mode register = 0.
  - Memory contents not reset.
  - Reset mid-operation discards all contents and any pending dout_valid.
- Mode register: loads block_mode on every clock where registered empty = 1. Otherwise held. Loading streaming forces direction = 0.
- Write accept (wa) = write_en && !full && (mode==0 || direction==0). Stores din at wptr; wptr += 1, wrapping mod depth.
- Read accept (ra) = read_en && !empty && (mode==0 || direction==1). Reads mem[rptr]; rptr += 1, wrapping.
- Latency: dout <= mem[rptr] at the accepting edge; dout_valid = 1 for exactly the following cycle. dout holds its value when no read occurs.
- Count: +1 on wa only, -1 on ra only, unchanged on both or neither.
- Flags are registered and derived from the next count, so they are coincident with data_count.
- Full/empty decisions use registered state only:
  - No read-through when empty: write+read at count 0 accepts the write, rejects the read.
  - No write-through when full: at count == depth the write is rejected even with a simultaneous read.
- Errors, streaming mode:
  - write_en && full sets overflow_err.
  - read_en && empty sets underflow_err.
- Block mode state machine:
  - FILL (direction=0): read_en is ignored, with no error. The write that brings count to depth also sets direction = 1 at the same edge.
  - DRAIN (direction=1): write_en sets overflow_err and the data is dropped. The read that brings count to 0 also sets direction = 0 at the same edge.
  - read_en with empty in DRAIN cannot occur; if it does, it sets underflow_err.
- clear_err clears both sticky flags. If an error event occurs in the same cycle, set wins.
- Memory: inferred simple dual-port block RAM, synchronous write and synchronous read, same clk.

Test Plan:
1. addr_width=3: 8 writes 0x000001..0x000008 -> data_count=8, full=1, empty=0. 9th write -> overflow_err=1, data_count stays 8. 8 reads -> dout 0x000001..0x000008 in order, dout_valid one cycle after each read_en, then empty=1.
2. Streaming at count=4, write_en=read_en=1 for 10 cycles with an incrementing pattern -> data_count stays 4, output order preserved across pointer wrap.
3. Empty FIFO, write_en=read_en=1 in one cycle -> write accepted, read rejected, underflow_err=1, data_count=1. clear_err with no event -> underflow_err=0.
4. block_mode=1, addr_width=3: read_en held high during fill -> no dout_valid and no error. direction=1 on the edge of the 8th write. Writes during drain -> overflow_err=1. 8 reads -> direction=0, empty=1 on the last-read edge.
5. af_thresh=6, ae_thresh=2, depth 8: almost_empty=1 for counts 0..2, almost_full=1 for counts 6..8, checked on each write and then each read.
6. Assert rst at count=5 during a read -> next cycle data_count=0, empty=1, dout_valid=0, dout=0, errors=0, direction=0. Writes accepted immediately after release.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Single-clock sample FIFO controller with streaming and block (fill/drain)
// modes, occupancy count, threshold flags, registered read data with a valid
// strobe, and sticky overflow/underflow error flags.
module sync_fifo_ctrl #(
  parameter int addr_width = 12,
  parameter int data_width = 24,
  parameter int af_thresh  = (1 << addr_width) - 4,
  parameter int ae_thresh  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  block_mode,
  input  logic                  write_en,
  input  logic [data_width-1:0] din,
  input  logic                  read_en,
  input  logic                  clear_err,
  output logic [data_width-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   data_count,
  output logic                  direction,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int depth = 1 << addr_width;
  localparam logic [addr_width:0] cnt_full = depth[addr_width:0];
  localparam logic [addr_width:0] af_level = af_thresh[addr_width:0];
  localparam logic [addr_width:0] ae_level = ae_thresh[addr_width:0];

  logic [data_width-1:0] mem [depth];
  logic [addr_width-1:0] wptr;
  logic [addr_width-1:0] rptr;
  logic                  mode;

  logic                  wa;
  logic                  ra;
  logic                  ovf_evt;
  logic                  unf_evt;
  logic [addr_width:0]   cnt_nxt;
  logic                  dir_nxt;
  logic                  mode_nxt;

  // Accept decisions, error events, next count, and block-mode direction.
  always_comb begin
    wa       = write_en && !full && (!mode || !direction);
    ra       = read_en && !empty && (!mode || direction);
    // Any rejected write is an overflow; in DRAIN every write is rejected.
    ovf_evt  = write_en && !wa;
    // A read ignored during FILL is not an error.
    unf_evt  = read_en && empty && (!mode || direction);

    cnt_nxt  = data_count;
    case ({wa, ra})
      2'b10:   cnt_nxt = data_count + 1'b1;
      2'b01:   cnt_nxt = data_count - 1'b1;
      default: cnt_nxt = data_count;
    endcase

    dir_nxt  = direction;
    if (mode) begin
      if (!direction && wa && (cnt_nxt == cnt_full)) dir_nxt = 1'b1;
      if (direction && ra && (cnt_nxt == '0))        dir_nxt = 1'b0;
    end

    // Mode is only allowed to change while the FIFO holds nothing.
    mode_nxt = mode;
    if (empty) begin
      mode_nxt = block_mode;
      if (!block_mode) dir_nxt = 1'b0;
    end
  end

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wa) mem[wptr] <= din;
  end

  // Registered read port and its one-cycle valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= ra;
      if (ra) dout <= mem[rptr];
    end
  end

  // Pointers, occupancy, flags derived from the next count, mode and errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      data_count    <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
      mode          <= 1'b0;
      direction     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wa) wptr <= wptr + 1'b1;
      if (ra) rptr <= rptr + 1'b1;
      data_count   <= cnt_nxt;
      full         <= (cnt_nxt == cnt_full);
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= af_level);
      almost_empty <= (cnt_nxt <= ae_level);
      mode         <= mode_nxt;
      direction    <= dir_nxt;
      // A new error event wins over a simultaneous clear.
      if (ovf_evt)        overflow_err  <= 1'b1;
      else if (clear_err) overflow_err  <= 1'b0;
      if (unf_evt)        underflow_err <= 1'b1;
      else if (clear_err) underflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed testbench for sync_fifo_ctrl with depth 8, af=6, ae=2.
module tb_sync_fifo_ctrl;

  localparam int AW = 3;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          block_mode;
  logic          write_en;
  logic [DW-1:0] din;
  logic          read_en;
  logic          clear_err;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   data_count;
  logic          direction;
  logic          overflow_err;
  logic          underflow_err;

  int checks   = 0;
  int failures = 0;

  sync_fifo_ctrl #(
    .addr_width(AW),
    .data_width(DW),
    .af_thresh (6),
    .ae_thresh (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .block_mode   (block_mode),
    .write_en     (write_en),
    .din          (din),
    .read_en      (read_en),
    .clear_err    (clear_err),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .direction    (direction),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one set of requests for a single clock edge, then sample 1 time unit later.
  task automatic step(input logic we, input logic [DW-1:0] d, input logic re, input logic ce);
    write_en  = we;
    din       = d;
    read_en   = re;
    clear_err = ce;
    @(posedge clk);
    #1;
    write_en  = 1'b0;
    read_en   = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic check_levels(input string tag, input int cnt);
    check({tag, "_count"}, 32'(data_count), 32'(cnt));
    check({tag, "_ae"},    32'(almost_empty), 32'(cnt <= 2));
    check({tag, "_af"},    32'(almost_full),  32'(cnt >= 6));
    check({tag, "_empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, "_full"},  32'(full),  32'(cnt == 8));
  endtask

  initial begin
    rst        = 1'b1;
    block_mode = 1'b0;
    write_en   = 1'b0;
    din        = '0;
    read_en    = 1'b0;
    clear_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_levels("rst", 0);
    check("rst_dout",  32'(dout), 32'h0);
    check("rst_vld",   32'(dout_valid), 32'h0);
    check("rst_dir",   32'(direction), 32'h0);
    check("rst_ovf",   32'(overflow_err), 32'h0);
    check("rst_unf",   32'(underflow_err), 32'h0);

    // Fill to full in streaming mode, threshold flags on every write
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      check_levels("fill", i);
    end
    step(1'b1, 24'h000009, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow_err), 32'h1);
    check_levels("ovf", 8);
    // Write+read at full with clear: write rejected, read accepted, set beats clear
    step(1'b1, 24'h000999, 1'b1, 1'b1);
    check("wf_vld",  32'(dout_valid), 32'h1);
    check("wf_dout", 32'(dout), 32'h000001);
    check("wf_ovf",  32'(overflow_err), 32'h1);
    check_levels("wf", 7);
    for (int i = 2; i <= 8; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("rd_vld",  32'(dout_valid), 32'h1);
      check("rd_dout", 32'(dout), 32'(i));
      check_levels("rd", 8 - i);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    check("idle_vld",  32'(dout_valid), 32'h0);
    check("idle_dout", 32'(dout), 32'h000008);
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow_err), 32'h0);

    // Streaming at count 4 with simultaneous read/write across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, 24'h000100 + DW'(i), 1'b0, 1'b0);
    check("s_cnt4", 32'(data_count), 32'd4);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 24'h000104 + DW'(k), 1'b1, 1'b0);
      check("s_dout", 32'(dout), 32'h100 + 32'(k));
      check("s_vld",  32'(dout_valid), 32'h1);
      check("s_cnt",  32'(data_count), 32'd4);
    end
    for (int k = 10; k < 14; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("s_tail", 32'(dout), 32'h100 + 32'(k));
    end
    check("s_empty", 32'(empty), 32'h1);
    check("s_ovf",   32'(overflow_err), 32'h0);
    check("s_unf",   32'(underflow_err), 32'h0);

    // Write+read on empty: write accepted, read rejected with underflow
    step(1'b1, 24'h000ABC, 1'b1, 1'b0);
    check("e_cnt", 32'(data_count), 32'd1);
    check("e_unf", 32'(underflow_err), 32'h1);
    check("e_vld", 32'(dout_valid), 32'h0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("e_clr", 32'(underflow_err), 32'h0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("e_dout", 32'(dout), 32'h000ABC);

    // Block mode: fill with read_en held, then drain
    block_mode = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 24'h000200 + DW'(i), 1'b1, 1'b0);
      check("b_vld", 32'(dout_valid), 32'h0);
      check("b_unf", 32'(underflow_err), 32'h0);
      check("b_dir", 32'(direction), 32'(i == 8));
      check("b_cnt", 32'(data_count), 32'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check("d_first", 32'(dout), 32'h000201);
    check("d_cnt7",  32'(data_count), 32'd7);
    step(1'b1, 24'h00DEAD, 1'b0, 1'b0);
    check("d_ovf",   32'(overflow_err), 32'h1);
    check("d_cnt",   32'(data_count), 32'd7);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 2; i <= 8; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("d_dout",  32'(dout), 32'h200 + 32'(i));
      check("d_dir",   32'(direction), 32'(i != 8));
      check("d_empty", 32'(empty), 32'(i == 8));
    end
    block_mode = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);

    // Reset during a read at count 5, with a sticky error pending
    step(1'b0, '0, 1'b1, 1'b0);
    check("r_unf", 32'(underflow_err), 32'h1);
    for (int i = 1; i <= 5; i++) step(1'b1, 24'h000300 + DW'(i), 1'b0, 1'b0);
    check("r_cnt5", 32'(data_count), 32'd5);
    read_en = 1'b1;
    @(posedge clk);
    #1;
    check("r_pre_vld", 32'(dout_valid), 32'h1);
    rst = 1'b1;
    #1;
    check_levels("r", 0);
    check("r_vld",  32'(dout_valid), 32'h0);
    check("r_dout", 32'(dout), 32'h0);
    check("r_dir",  32'(direction), 32'h0);
    check("r_ovf",  32'(overflow_err), 32'h0);
    check("r_unf0", 32'(underflow_err), 32'h0);
    read_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 24'h000401, 1'b0, 1'b0);
    check("r_wr", 32'(data_count), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("r_rd", 32'(dout), 32'h000401);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
